// File: rtl/sound_trigger_player.sv
// ============================================================================
// Module      : sound_trigger_player
// Description : Synchronises the pmod1/pmod2 sound triggers and plays the start
//               or goal jingle as a square wave on the buzzer output.
//               Optional build macro: MUTE_PIN_EN (pmod4 mutes the buzzer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sound_trigger_player #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pmod1,
    input  logic       pmod2,
    input  logic       pmod4,
    output logic       buzzer,
    output logic       busy,
    output logic       melody,
    output logic [1:0] note_idx,
    output logic       done
);

    localparam int HP_C5 = CLK_HZ / (2 * 523);
    localparam int HP_E5 = CLK_HZ / (2 * 659);
    localparam int HP_G5 = CLK_HZ / (2 * 784);
    localparam int HP_C6 = CLK_HZ / (2 * 1047);

    // C5 is the lowest note, so its half-period bounds the tone counter.
    localparam int TONE_W  = (HP_C5 > 1) ? $clog2(HP_C5) : 1;
    localparam int DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

    localparam logic [TONE_W-1:0] HPM1_C5   = TONE_W'(HP_C5 - 1);
    localparam logic [TONE_W-1:0] HPM1_E5   = TONE_W'(HP_E5 - 1);
    localparam logic [TONE_W-1:0] HPM1_G5   = TONE_W'(HP_G5 - 1);
    localparam logic [TONE_W-1:0] HPM1_C6   = TONE_W'(HP_C6 - 1);
    localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          p1_sync;
    logic [1:0]          p2_sync;
    logic                p1_d;
    logic                p2_d;
    logic                rise1;
    logic                rise2;
    logic [TONE_W-1:0]   tone_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic [TONE_W-1:0]   hp_m1;
    logic                last_note;
    logic                tone;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_sync <= 2'b00;
            p2_sync <= 2'b00;
            p1_d    <= 1'b0;
            p2_d    <= 1'b0;
        end else begin
            p1_sync <= {p1_sync[0], pmod1};
            p2_sync <= {p2_sync[0], pmod2};
            p1_d    <= p1_sync[1];
            p2_d    <= p2_sync[1];
        end
    end

    assign rise1 = p1_sync[1] & ~p1_d;
    assign rise2 = p2_sync[1] & ~p2_d;

    always_comb begin
        hp_m1 = HPM1_C6;
        case ({melody, note_idx})
            3'b000:  hp_m1 = HPM1_C5;
            3'b001:  hp_m1 = HPM1_E5;
            3'b010:  hp_m1 = HPM1_G5;
            3'b011:  hp_m1 = HPM1_C6;
            3'b100:  hp_m1 = HPM1_G5;
            default: hp_m1 = HPM1_C6;
        endcase
    end

    assign last_note = melody ? (note_idx == 2'd2) : (note_idx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            melody   <= 1'b0;
            note_idx <= 2'd0;
            done     <= 1'b0;
            tone     <= 1'b0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
        end else begin
            done <= 1'b0;
            // A goal trigger always (re)starts the goal jingle; start only from idle.
            if (rise2 || (state == IDLE && rise1)) begin
                state    <= PLAY;
                busy     <= 1'b1;
                melody   <= rise2;
                note_idx <= 2'd0;
                tone     <= 1'b0;
                tone_cnt <= '0;
                dur_cnt  <= '0;
            end else begin
                case (state)
                    PLAY: begin
                        if (dur_cnt == NOTE_LAST) begin
                            state    <= GAP;
                            dur_cnt  <= '0;
                            tone     <= 1'b0;
                            tone_cnt <= '0;
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                            if (tone_cnt == hp_m1) begin
                                tone_cnt <= '0;
                                tone     <= ~tone;
                            end else begin
                                tone_cnt <= tone_cnt + TONE_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (dur_cnt == GAP_LAST) begin
                            dur_cnt <= '0;
                            if (last_note) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= PLAY;
                                note_idx <= note_idx + 2'd1;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MUTE_PIN_EN
    logic [1:0] mute_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mute_sync <= 2'b00;
        end else begin
            mute_sync <= {mute_sync[0], pmod4};
        end
    end

    assign buzzer = tone & ~mute_sync[1];
`else
    logic unused_pmod4;

    assign unused_pmod4 = pmod4;
    assign buzzer       = tone;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sound_trigger_player.sv
// ============================================================================
// Module      : tb_sound_trigger_player
// Description : Scoreboard bench for sound_trigger_player (short-tick build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sound_trigger_player;

    localparam int CLK_HZ = 1_000_000;
    localparam int NOTE   = 2000;
    localparam int GAP    = 500;
    localparam int SLOT   = NOTE + GAP;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       pmod1 = 1'b0;
    logic       pmod2 = 1'b0;
    logic       pmod4 = 1'b0;
    logic       buzzer;
    logic       busy;
    logic       melody;
    logic [1:0] note_idx;
    logic       done;

    sound_trigger_player #(
        .CLK_HZ     (CLK_HZ),
        .NOTE_TICKS (NOTE),
        .GAP_TICKS  (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .pmod1    (pmod1),
        .pmod2    (pmod2),
        .pmod4    (pmod4),
        .buzzer   (buzzer),
        .busy     (busy),
        .melody   (melody),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int obs_lat;
    int obs_mel;
    int obs_done_at;
    int obs_done_cnt;
    int obs_gap_hi;
    int obs_rise [4];

    function automatic int hp(input int f);
        return CLK_HZ / (2 * f);
    endfunction

    task automatic push_exp(input string n, input int v);
        sb.push_back('{name: n, val: v});
    endtask

    // Expected observation record for one full jingle, in observe() order.
    task automatic push_jingle(input logic mel, input logic muted);
        int hps [4];
        int notes;
        if (mel) begin
            hps   = '{hp(784), hp(1047), hp(1047), 0};
            notes = 3;
        end else begin
            hps   = '{hp(523), hp(659), hp(784), hp(1047)};
            notes = 4;
        end
        push_exp("latency", 3);
        push_exp("melody", int'(mel));
        for (int n = 0; n < 4; n++)
            push_exp($sformatf("rise_note%0d", n), (n < notes && !muted) ? n * SLOT + hps[n] : -1);
        push_exp("done_at", notes * SLOT);
        push_exp("done_cnt", 1);
        push_exp("gap_buzz", 0);
    endtask

    // Offsets are counted from the first sample with busy high.
    task automatic observe(input int budget);
        int   entry;
        logic prev;
        entry        = -1;
        prev         = 1'b0;
        obs_lat      = -1;
        obs_mel      = -1;
        obs_done_at  = -1;
        obs_done_cnt = 0;
        obs_gap_hi   = 0;
        for (int n = 0; n < 4; n++) obs_rise[n] = -1;
        for (int t = 1; t <= budget; t++) begin
            @(negedge clk);
            if (t == 5) begin
                pmod1 = 1'b0;
                pmod2 = 1'b0;
            end
            if (entry < 0 && busy) begin
                entry   = t;
                obs_lat = t;
                obs_mel = int'(melody);
            end
            if (entry >= 0) begin
                if (busy && buzzer && !prev && obs_rise[note_idx] < 0)
                    obs_rise[note_idx] = t - entry;
                if (busy && buzzer && ((t - entry) % SLOT) >= NOTE)
                    obs_gap_hi++;
                if (done) begin
                    obs_done_cnt++;
                    if (obs_done_at < 0) obs_done_at = t - entry;
                end
                if (obs_done_at >= 0 && (t - entry) > obs_done_at + 20) break;
            end
            prev = buzzer;
        end
        pmod1 = 1'b0;
        pmod2 = 1'b0;
    endtask

    task automatic test_reset();
        int   obs[$];
        exp_t e;
        push_exp("rst_buzzer", 0);
        push_exp("rst_busy", 0);
        push_exp("rst_melody", 0);
        push_exp("rst_note_idx", 0);
        push_exp("rst_done", 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {int'(buzzer), int'(busy), int'(melody), int'(note_idx), int'(done)};
        foreach (obs[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs[i] !== e.val) begin
                errors++;
                $display("FAIL reset.%s got %0d expected %0d", e.name, obs[i], e.val);
            end
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_start_jingle();
        int   obs[$];
        exp_t e;
        push_jingle(1'b0, 1'b0);
        pmod1 = 1'b1;
        observe(4 * SLOT + 100);
        obs = {obs_lat, obs_mel, obs_rise[0], obs_rise[1], obs_rise[2], obs_rise[3],
               obs_done_at, obs_done_cnt, obs_gap_hi};
        foreach (obs[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs[i] !== e.val) begin
                errors++;
                $display("FAIL start.%s got %0d expected %0d", e.name, obs[i], e.val);
            end
        end
    endtask

    task automatic test_goal_jingle();
        int   obs[$];
        exp_t e;
        push_jingle(1'b1, 1'b0);
        pmod2 = 1'b1;
        observe(4 * SLOT + 100);
        obs = {obs_lat, obs_mel, obs_rise[0], obs_rise[1], obs_rise[2], obs_rise[3],
               obs_done_at, obs_done_cnt, obs_gap_hi};
        foreach (obs[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs[i] !== e.val) begin
                errors++;
                $display("FAIL goal.%s got %0d expected %0d", e.name, obs[i], e.val);
            end
        end
    endtask

    task automatic test_simultaneous();
        int   obs[$];
        exp_t e;
        push_jingle(1'b1, 1'b0);
        pmod1 = 1'b1;
        pmod2 = 1'b1;
        observe(4 * SLOT + 100);
        obs = {obs_lat, obs_mel, obs_rise[0], obs_rise[1], obs_rise[2], obs_rise[3],
               obs_done_at, obs_done_cnt, obs_gap_hi};
        foreach (obs[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs[i] !== e.val) begin
                errors++;
                $display("FAIL both.%s got %0d expected %0d", e.name, obs[i], e.val);
            end
        end
    endtask

    task automatic test_preempt();
        int   obs[$];
        exp_t e;
        int   t;
        int   dcnt;
        int   dat;
        int   mid;
        push_exp("idx_before", 2);
        push_exp("mel_before", 0);
        push_exp("idx_after", 0);
        push_exp("mel_after", 1);
        push_exp("mel_mid", 1);
        push_exp("done_at", 3 * SLOT);
        push_exp("done_cnt", 1);
        pmod1 = 1'b1;
        repeat (4) @(negedge clk);
        pmod1 = 1'b0;
        t = 0;
        while (note_idx != 2'd2 && t < 3 * SLOT) begin
            @(negedge clk);
            t++;
        end
        repeat (100) @(negedge clk);
        pmod2 = 1'b1;
        repeat (2) @(negedge clk);
        obs.push_back(int'(note_idx));
        obs.push_back(int'(melody));
        @(negedge clk);
        obs.push_back(int'(note_idx));
        obs.push_back(int'(melody));
        pmod2 = 1'b0;
        dcnt  = 0;
        dat   = -1;
        mid   = -1;
        for (int k = 1; k <= 5 * SLOT; k++) begin
            @(negedge clk);
            if (k == 1000) pmod1 = 1'b1;
            if (k == 1005) pmod1 = 1'b0;
            if (k == 1010) mid = int'(melody);
            if (done) begin
                dcnt++;
                if (dat < 0) dat = k;
            end
            if (dat >= 0 && k > dat + 20) break;
        end
        obs.push_back(mid);
        obs.push_back(dat);
        obs.push_back(dcnt);
        foreach (obs[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs[i] !== e.val) begin
                errors++;
                $display("FAIL preempt.%s got %0d expected %0d", e.name, obs[i], e.val);
            end
        end
    endtask

    task automatic test_reset_mid_note();
        int   obs[$];
        exp_t e;
        int   t;
        int   busy_hi;
        push_exp("busy_before", 1);
        push_exp("buzzer_in_rst", 0);
        push_exp("busy_in_rst", 0);
        push_exp("done_in_rst", 0);
        push_exp("busy_after_cnt", 0);
        pmod1 = 1'b1;
        repeat (4) @(negedge clk);
        pmod1 = 1'b0;
        t = 0;
        while (buzzer !== 1'b1 && t < 2 * SLOT) begin
            @(negedge clk);
            t++;
        end
        obs.push_back(int'(busy));
        #1;
        rst_n = 1'b0;
        #1;
        obs.push_back(int'(buzzer));
        obs.push_back(int'(busy));
        obs.push_back(int'(done));
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        busy_hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy || buzzer || done) busy_hi++;
        end
        obs.push_back(busy_hi);
        foreach (obs[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs[i] !== e.val) begin
                errors++;
                $display("FAIL rst_mid.%s got %0d expected %0d", e.name, obs[i], e.val);
            end
        end
    endtask

    task automatic test_mute();
        int   obs[$];
        exp_t e;
`ifdef MUTE_PIN_EN
        push_jingle(1'b0, 1'b1);
`else
        push_jingle(1'b0, 1'b0);
`endif
        pmod4 = 1'b1;
        repeat (5) @(negedge clk);
        pmod1 = 1'b1;
        observe(4 * SLOT + 100);
        pmod4 = 1'b0;
        obs = {obs_lat, obs_mel, obs_rise[0], obs_rise[1], obs_rise[2], obs_rise[3],
               obs_done_at, obs_done_cnt, obs_gap_hi};
        foreach (obs[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs[i] !== e.val) begin
                errors++;
                $display("FAIL mute.%s got %0d expected %0d", e.name, obs[i], e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_jingle();
        test_goal_jingle();
        test_simultaneous();
        test_preempt();
        test_reset_mid_note();
        test_mute();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
